// File: rtl/sep_switch_allocator_pkg.sv
// Shared NoC definitions: default router dimensions, index-width helpers and the QoS class type.
package sep_switch_allocator_pkg;

    localparam int NUM_PORTS_DEF  = 5;
    localparam int NUM_VCS_DEF    = 4;
    localparam int QOS_LEVELS_DEF = 4;

    // A single-entry field still needs one bit so that ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int port_w(input int num_ports);
        return idx_width(num_ports);
    endfunction

    function automatic int vc_w(input int num_vcs);
        return idx_width(num_vcs);
    endfunction

    function automatic int qos_w(input int qos_levels);
        return idx_width(qos_levels);
    endfunction

    localparam int QW_DEF = qos_w(QOS_LEVELS_DEF);

    typedef logic [QW_DEF-1:0] qos_level_t;

endpackage

// File: rtl/sep_switch_allocator_rr_prio_arbiter.sv
// Combinational arbiter: highest priority value wins, ties broken round-robin starting at ptr.
module rr_prio_arbiter
    import sep_switch_allocator_pkg::*;
#(
    parameter int N   = 4,
    parameter int PRW = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N*PRW-1:0] prio,
    input  logic [IW-1:0]    ptr,
    output logic             gnt_valid,
    output logic [IW-1:0]    gnt_idx
);

    logic [PRW-1:0] best;
    logic [IW-1:0]  rot_idx [N];

    always_comb begin
        best      = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (prio[i*PRW +: PRW] > best)) begin
                best = prio[i*PRW +: PRW];
            end
        end
        // Scan from the pointer so equal-priority requesters take turns.
        for (int k = 0; k < N; k++) begin
            rot_idx[k] = IW'((int'(ptr) + k) % N);
            if (!gnt_valid && req[rot_idx[k]] && (prio[int'(rot_idx[k])*PRW +: PRW] == best)) begin
                gnt_valid = 1'b1;
                gnt_idx   = rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/sep_switch_allocator.sv
// Separable input-first switch allocator with wormhole output locking, QoS and age promotion.
module sep_switch_allocator
    import sep_switch_allocator_pkg::*;
#(
    parameter int NUM_PORTS  = NUM_PORTS_DEF,
    parameter int NUM_VCS    = NUM_VCS_DEF,
    parameter int QOS_LEVELS = QOS_LEVELS_DEF,
    parameter int AGE_THRESH = 16,
    localparam int PW = port_w(NUM_PORTS),
    localparam int VW = vc_w(NUM_VCS),
    localparam int QW = qos_w(QOS_LEVELS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*NUM_VCS-1:0]    req_valid,
    input  logic [NUM_PORTS*NUM_VCS*PW-1:0] req_outport,
    input  logic [NUM_PORTS*NUM_VCS*QW-1:0] req_qos,
    input  logic [NUM_PORTS*NUM_VCS-1:0]    req_tail,
    input  logic [NUM_PORTS-1:0]            out_ready,
    input  logic                            qos_enable,
    output logic [NUM_PORTS-1:0]            in_grant,
    output logic [NUM_PORTS*VW-1:0]         in_grant_vc,
    output logic [NUM_PORTS-1:0]            xbar_valid,
    output logic [NUM_PORTS*PW-1:0]         xbar_sel,
    output logic [NUM_PORTS-1:0]            out_locked,
    output logic [31:0]                     grant_count
);

    localparam int NR = NUM_PORTS * NUM_VCS;
    localparam int SW = QW + 1;

    logic [PW-1:0]             req_op [NR];
    logic [NR-1:0]             elig;
    logic [NR*QW-1:0]          s1_prio;
    logic [NUM_PORTS-1:0]      lock_vld;
    logic [PW-1:0]             lock_in [NUM_PORTS];
    logic [VW-1:0]             lock_vc [NUM_PORTS];
    logic [VW-1:0]             in_ptr  [NUM_PORTS];
    logic [PW-1:0]             out_ptr [NUM_PORTS];
    logic [7:0]                age     [NUM_PORTS];
    logic [NUM_PORTS-1:0]      s1_vld;
    logic [NUM_PORTS-1:0]      s1_tail;
    logic [NUM_PORTS-1:0]      any_elig;
    logic [VW-1:0]             s1_vc   [NUM_PORTS];
    logic [PW-1:0]             s1_op   [NUM_PORTS];
    logic [NUM_PORTS*SW-1:0]   s2_prio;
    logic [NUM_PORTS*NUM_PORTS-1:0] s2_req;
    logic [NUM_PORTS-1:0]      s2_vld;
    logic [PW-1:0]             s2_in   [NUM_PORTS];
    logic [NUM_PORTS-1:0]      gnt;
    logic [31:0]               gnt_pop;

    assign out_locked = lock_vld;
    assign s1_prio    = qos_enable ? req_qos : '0;

    // A locked output is visible only to its owning (input, vc); everyone else is masked.
    always_comb begin
        for (int k = 0; k < NR; k++) begin
            req_op[k] = req_outport[k*PW +: PW];
            elig[k]   = 1'b0;
            if (req_valid[k] && (int'(req_op[k]) < NUM_PORTS)) begin
                if (out_ready[req_op[k]] &&
                    (!lock_vld[req_op[k]] ||
                     ((int'(lock_in[req_op[k]]) == k / NUM_VCS) &&
                      (int'(lock_vc[req_op[k]]) == k % NUM_VCS)))) begin
                    elig[k] = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_s1
        rr_prio_arbiter #(.N(NUM_VCS), .PRW(QW)) u_arb (
            .req       (elig[i*NUM_VCS +: NUM_VCS]),
            .prio      (s1_prio[i*NUM_VCS*QW +: NUM_VCS*QW]),
            .ptr       (in_ptr[i]),
            .gnt_valid (s1_vld[i]),
            .gnt_idx   (s1_vc[i])
        );
    end

    // Stage-2 priority is {aged, qos}: an aged input beats any QoS class.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            any_elig[i] = |elig[i*NUM_VCS +: NUM_VCS];
            s1_op[i]    = req_op[i*NUM_VCS + int'(s1_vc[i])];
            s1_tail[i]  = req_tail[i*NUM_VCS + int'(s1_vc[i])];
            s2_prio[i*SW + QW] = (int'(age[i]) >= AGE_THRESH);
            s2_prio[i*SW +: QW] = qos_enable ? req_qos[(i*NUM_VCS + int'(s1_vc[i]))*QW +: QW] : '0;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                s2_req[o*NUM_PORTS + i] = s1_vld[i] && (int'(s1_op[i]) == o);
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_s2
        rr_prio_arbiter #(.N(NUM_PORTS), .PRW(SW)) u_arb (
            .req       (s2_req[o*NUM_PORTS +: NUM_PORTS]),
            .prio      (s2_prio),
            .ptr       (out_ptr[o]),
            .gnt_valid (s2_vld[o]),
            .gnt_idx   (s2_in[o])
        );
    end

    always_comb begin
        gnt     = '0;
        gnt_pop = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (s2_vld[o]) begin
                gnt[s2_in[o]] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            gnt_pop = gnt_pop + 32'(gnt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_grant    <= '0;
            in_grant_vc <= '0;
            xbar_valid  <= '0;
            xbar_sel    <= '0;
            grant_count <= '0;
            lock_vld    <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                lock_in[i] <= '0;
                lock_vc[i] <= '0;
                in_ptr[i]  <= '0;
                out_ptr[i] <= '0;
                age[i]     <= '0;
            end
        end else begin
            in_grant    <= gnt;
            xbar_valid  <= s2_vld;
            grant_count <= grant_count + gnt_pop;
            for (int i = 0; i < NUM_PORTS; i++) begin
                in_grant_vc[i*VW +: VW] <= gnt[i] ? s1_vc[i] : '0;
                if (gnt[i]) begin
                    in_ptr[i] <= (int'(s1_vc[i]) == NUM_VCS - 1) ? '0 : s1_vc[i] + 1'b1;
                end
                if (any_elig[i] && !gnt[i]) begin
                    age[i] <= (age[i] == 8'hff) ? age[i] : age[i] + 8'd1;
                end else begin
                    age[i] <= '0;
                end
            end
            for (int o = 0; o < NUM_PORTS; o++) begin
                xbar_sel[o*PW +: PW] <= s2_vld[o] ? s2_in[o] : '0;
                if (s2_vld[o]) begin
                    out_ptr[o] <= (int'(s2_in[o]) == NUM_PORTS - 1) ? '0 : s2_in[o] + 1'b1;
                    lock_vld[o] <= !s1_tail[s2_in[o]];
                    lock_in[o]  <= s2_in[o];
                    lock_vc[o]  <= s1_vc[s2_in[o]];
                end
            end
        end
    end

endmodule

// File: tb/tb_sep_switch_allocator.sv
// Directed bench for sep_switch_allocator: stimulus queues expected grant records, a monitor compares them.
module tb_sep_switch_allocator;

    localparam int NP = 5;
    localparam int NV = 4;
    localparam int PW = 3;
    localparam int QW = 2;
    localparam int VW = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NP*NV-1:0]      req_valid;
    logic [NP*NV*PW-1:0]   req_outport;
    logic [NP*NV*QW-1:0]   req_qos;
    logic [NP*NV-1:0]      req_tail;
    logic [NP-1:0]         out_ready;
    logic                  qos_enable;
    logic [NP-1:0]         in_grant;
    logic [NP*VW-1:0]      in_grant_vc;
    logic [NP-1:0]         xbar_valid;
    logic [NP*PW-1:0]      xbar_sel;
    logic [NP-1:0]         out_locked;
    logic [31:0]           grant_count;

    sep_switch_allocator #(.AGE_THRESH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_outport (req_outport),
        .req_qos     (req_qos),
        .req_tail    (req_tail),
        .out_ready   (out_ready),
        .qos_enable  (qos_enable),
        .in_grant    (in_grant),
        .in_grant_vc (in_grant_vc),
        .xbar_valid  (xbar_valid),
        .xbar_sel    (xbar_sel),
        .out_locked  (out_locked),
        .grant_count (grant_count)
    );

    typedef struct packed {
        int                cyc;
        logic [NP-1:0]     g;
        logic [NP*VW-1:0]  gvc;
        logic [NP-1:0]     xv;
        logic [NP*PW-1:0]  xs;
        logic [NP-1:0]     lk;
        logic [31:0]       gc;
    } rec_t;

    rec_t exp_q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && (in_grant != '0)) begin
            rec_t a;
            rec_t e;
            a.cyc = cyc;
            a.g   = in_grant;
            a.gvc = in_grant_vc;
            a.xv  = xbar_valid;
            a.xs  = xbar_sel;
            a.lk  = out_locked;
            a.gc  = grant_count;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_grant: got in_grant=%b at cycle %0d, required no grant", in_grant, cyc);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL grant_rec: got cyc=%0d g=%b vc=%h xv=%b xs=%h lk=%b gc=%0d, required cyc=%0d g=%b vc=%h xv=%b xs=%h lk=%b gc=%0d",
                             a.cyc, a.g, a.gvc, a.xv, a.xs, a.lk, a.gc, e.cyc, e.g, e.gvc, e.xv, e.xs, e.lk, e.gc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic rec_t blank(input int c, input int lk, input int gc);
        rec_t r;
        r     = '0;
        r.cyc = c;
        r.lk  = NP'(lk);
        r.gc  = 32'(gc);
        return r;
    endfunction

    function automatic rec_t add(input rec_t r0, input int i, input int v, input int o);
        rec_t r;
        r = r0;
        r.g[i]              = 1'b1;
        r.gvc[i*VW +: VW]   = VW'(v);
        r.xv[o]             = 1'b1;
        r.xs[o*PW +: PW]    = PW'(i);
        return r;
    endfunction

    task automatic push(input int dly, input int i, input int v, input int o, input int lk, input int gc);
        exp_q.push_back(add(blank(cyc + dly, lk, gc), i, v, o));
    endtask

    task automatic clr_all();
        req_valid   = '0;
        req_outport = '0;
        req_qos     = '0;
        req_tail    = '0;
    endtask

    task automatic set_req(input int i, input int v, input int o, input int q, input bit t);
        int k;
        k = i*NV + v;
        req_valid[k]             = 1'b1;
        req_outport[k*PW +: PW]  = PW'(o);
        req_qos[k*QW +: QW]      = QW'(q);
        req_tail[k]              = t;
    endtask

    task automatic drop(input int i, input int v);
        req_valid[i*NV + v] = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_grant"},    64'(in_grant),    64'd0);
        chk({tag, "_in_grant_vc"}, 64'(in_grant_vc), 64'd0);
        chk({tag, "_xbar_valid"},  64'(xbar_valid),  64'd0);
        chk({tag, "_xbar_sel"},    64'(xbar_sel),    64'd0);
        chk({tag, "_out_locked"},  64'(out_locked),  64'd0);
        chk({tag, "_grant_count"}, 64'(grant_count), 64'd0);
    endtask

    task automatic do_reset();
        tick();
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        rst_n = 1'b0;
        clr_all();
        out_ready  = '1;
        qos_enable = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        clr_all();
        out_ready  = '1;
        qos_enable = 1'b0;
        repeat (2) tick();
        #1;
        check_zero("por");
        rst_n = 1'b1;

        // Two single-flit requests to output 2: round-robin from pointer 0.
        do_reset();
        set_req(1, 0, 2, 1, 1);
        set_req(3, 0, 2, 1, 1);
        push(1, 1, 0, 2, 0, 1);
        tick();
        drop(1, 0);
        push(1, 3, 0, 2, 0, 2);
        tick();
        drop(3, 0);

        // Strict QoS: input 4 (qos 3) beats input 0 (qos 0) despite the pointer.
        do_reset();
        qos_enable = 1'b1;
        set_req(0, 0, 1, 0, 1);
        set_req(4, 0, 1, 3, 1);
        push(1, 4, 0, 1, 0, 1);
        tick();
        drop(4, 0);
        push(1, 0, 0, 1, 0, 2);
        tick();
        drop(0, 0);

        // Same traffic with QoS disabled: pure round-robin, input 0 first.
        do_reset();
        set_req(0, 0, 1, 0, 1);
        set_req(4, 0, 1, 3, 1);
        push(1, 0, 0, 1, 0, 1);
        tick();
        drop(0, 0);
        push(1, 4, 0, 1, 0, 2);
        tick();
        drop(4, 0);

        // Three-flit packet from input 2 VC1 holds output 0 until its tail.
        do_reset();
        set_req(2, 1, 0, 0, 0);
        push(1, 2, 1, 0, 5'b00001, 1);
        tick();
        set_req(0, 0, 0, 0, 1);
        push(1, 2, 1, 0, 5'b00001, 2);
        tick();
        set_req(2, 1, 0, 0, 1);
        push(1, 2, 1, 0, 0, 3);
        tick();
        drop(2, 1);
        push(1, 0, 0, 0, 0, 4);
        tick();
        drop(0, 0);

        // Aging: input 3 (qos 0) against constant qos-3 traffic, promoted on its 5th wait.
        do_reset();
        qos_enable = 1'b1;
        set_req(1, 0, 2, 3, 1);
        set_req(3, 0, 2, 0, 1);
        for (int k = 1; k <= 4; k++) push(k, 1, 0, 2, 0, k);
        push(5, 3, 0, 2, 0, 5);
        repeat (5) tick();
        clr_all();

        // Stage-1 QoS pick, two parallel grants, and an out-of-range request that never wins.
        do_reset();
        qos_enable = 1'b1;
        set_req(0, 0, 7, 3, 1);
        set_req(1, 0, 3, 0, 1);
        set_req(1, 2, 4, 2, 1);
        set_req(3, 1, 3, 1, 1);
        exp_q.push_back(add(add(blank(cyc + 1, 0, 2), 1, 2, 4), 3, 1, 3));
        tick();
        drop(1, 2);
        drop(3, 1);
        push(1, 1, 0, 3, 0, 3);
        tick();
        drop(1, 0);
        repeat (2) tick();
        clr_all();

        // Locked owner stalled by out_ready low, then resumes ahead of a masked competitor.
        do_reset();
        set_req(4, 3, 2, 0, 0);
        push(1, 4, 3, 2, 5'b00100, 1);
        tick();
        out_ready[2] = 1'b0;
        set_req(4, 3, 2, 0, 1);
        set_req(1, 0, 2, 0, 1);
        tick();
        chk("stall1_in_grant",   64'(in_grant),    64'd0);
        chk("stall1_xbar_valid", 64'(xbar_valid),  64'd0);
        chk("stall1_locked",     64'(out_locked),  64'b00100);
        tick();
        chk("stall2_in_grant",   64'(in_grant),    64'd0);
        chk("stall2_locked",     64'(out_locked),  64'b00100);
        chk("stall2_count",      64'(grant_count), 64'd1);
        out_ready[2] = 1'b1;
        push(1, 4, 3, 2, 0, 2);
        tick();
        drop(4, 3);
        push(1, 1, 0, 2, 0, 3);
        tick();
        drop(1, 0);

        // Reset in the middle of a packet clears everything; arbitration restarts from scratch.
        do_reset();
        set_req(2, 0, 3, 0, 0);
        push(1, 2, 0, 3, 5'b01000, 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midpkt");
        set_req(1, 0, 3, 0, 1);
        tick();
        rst_n = 1'b1;
        push(1, 1, 0, 3, 0, 1);
        tick();
        drop(1, 0);
        push(1, 2, 0, 3, 5'b01000, 2);
        tick();
        clr_all();
        tick();
        #1;
        chk("queue_drained_end", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sep_switch_allocator.md
SEP_SWITCH_ALLOCATOR -- requirements
Module: sep_switch_allocator

Interface
REQ-001 Parameter NUM_PORTS, default 5, router input/output port count (2..8).
REQ-002 Parameter NUM_VCS, default 4, virtual channels per input port (1..8).
REQ-003 Parameter QOS_LEVELS, default 4, priority classes; higher value is higher priority.
REQ-004 Parameter AGE_THRESH, default 16, wait cycles before an input is promoted (1..255).
REQ-005 clk  input  1  clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  NUM_PORTS*NUM_VCS  per (input,vc) head flit ready and VC allocated.
REQ-008 req_outport  input  NUM_PORTS*NUM_VCS*PW  requested output; PW=$clog2(NUM_PORTS).
REQ-009 req_qos  input  NUM_PORTS*NUM_VCS*QW  flit QoS class; QW=$clog2(QOS_LEVELS).
REQ-010 req_tail  input  NUM_PORTS*NUM_VCS  flit at head is a tail (single-flit packets set head and tail).
REQ-011 out_ready  input  NUM_PORTS  downstream has a credit on the output.
REQ-012 qos_enable  input  1  1: strict QoS priority; 0: pure round-robin.
REQ-013 in_grant  output  NUM_PORTS  per input, a flit is granted this cycle.
REQ-014 in_grant_vc  output  NUM_PORTS*VW  granted VC index; VW=$clog2(NUM_VCS).
REQ-015 xbar_valid  output  NUM_PORTS  per output, crossbar connection active.
REQ-016 xbar_sel  output  NUM_PORTS*PW  per output, selected input port.
REQ-017 out_locked  output  NUM_PORTS  per output, held by an unfinished packet.
REQ-018 grant_count  output  32  total grants since reset, wrapping.

Function
REQ-019 Eligible (i,v): req_valid set, out_ready[req_outport] set, and the target output unlocked or locked to (i,v).
REQ-020 Stage 1: per input, select one eligible VC; with qos_enable, highest req_qos wins; ties and qos_enable=0 use per-input round-robin pointer.
REQ-021 Stage 2: per output, select one input among stage-1 winners targeting it; priority: aged inputs first, then highest QoS (qos_enable=1), then per-output round-robin.
REQ-022 Stage-1 losers in stage 2 produce no grant that cycle; no second iteration.
REQ-023 Grant outputs are registered: request at cycle N yields in_grant/xbar at N+1.
REQ-024 Round-robin pointers advance to one past the winner only on an actual grant; unchanged otherwise.
REQ-025 Non-tail grant locks output to (i,v); lock clears on the cycle after the tail grant from (i,v).
REQ-026 While locked, all other requests to that output are masked regardless of QoS or age.
REQ-027 Locked owner withdrawing req_valid or out_ready low: lock retained, no grant, xbar_valid 0.
REQ-028 Per-input age counter (8 bits, saturating at 255) increments each cycle the input has an eligible VC but no grant; clears on grant or when no eligible VC.
REQ-029 Input is aged when counter >= AGE_THRESH; multiple aged inputs resolved by round-robin.
REQ-030 At most one grant per input and per output each cycle (matching property).
REQ-031 Out-of-range req_outport (>= NUM_PORTS) is ignored.
REQ-032 grant_count adds popcount(in_grant) each cycle, wrapping modulo 2^32.

Reset
REQ-033 On rst_n low: all outputs 0, locks cleared, pointers 0, age counters 0, grant_count 0, immediately and asynchronously.
REQ-034 Reset mid-packet discards locks; first grant after release follows normal arbitration.

Structure
REQ-035 NUM_PORTS/NUM_VCS defaults, PW/VW/QW width functions and the qos_level_t typedef belong in the shared NoC package.
REQ-036 One sub-module, rr_prio_arbiter (parametrised width, priority vector, round-robin pointer), instantiated per input and per output.

Verification
REQ-037 Default params, inputs 1 and 3 VC0 request output 2 single-flit, qos 1 each, pointer 0 -> cycle 1 grant input 1, cycle 2 input 3.
REQ-038 qos_enable=1, input 0 qos 0 and input 4 qos 3 to output 1 -> input 4 granted first.
REQ-039 Input 2 VC1 sends 3-flit packet to output 0 while input 0 competes -> out_locked[0] high; input 2 granted 3 consecutive cycles; input 0 only after tail.
REQ-040 qos_enable=1, input 3 qos 0 vs continuous qos-3 traffic from input 1, AGE_THRESH=4 -> input 3 granted within 6 cycles.
REQ-041 out_ready[2]=0 with locked owner requesting -> no grant, lock held; out_ready back to 1 -> owner granted next cycle.
REQ-042 rst_n asserted mid-packet -> all outputs 0 same cycle, out_locked 0, grant_count 0.
